// File: rtl/cpu_seq_pkg.sv
// Shared definitions for the CPU run sequencer: state encoding, word geometry
// and the halt opcode used by the core-side halt detector.
package cpu_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_RUN       = 3'd2,
    ST_DRAIN     = 3'd3,
    ST_DUMP_RD   = 3'd4,
    ST_DUMP_WAIT = 3'd5,
    ST_DUMP_OUT  = 3'd6
  } seq_state_t;

  localparam int WORD_BYTES = 4;
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  // Word index to byte address (word-aligned, stride WORD_BYTES).
  function automatic logic [31:0] word_addr(input logic [31:0] idx);
    return idx << $clog2(WORD_BYTES);
  endfunction

endpackage

// File: rtl/seq_counter.sv
// Up-counter with synchronous clear (priority over enable) and an equality
// compare against a caller-supplied terminal value.
module seq_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic [W-1:0] count,
  output logic         at_term
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

  assign at_term = (count == term);

endmodule

// File: rtl/cpu_run_sequencer.sv
// Sequences one program run of the CPU core: load instruction memory, run,
// drain the pipeline, then stream data memory back out to the host.
module cpu_run_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int IMEM_WORDS   = 512,
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [31:0]      load_data,
  input  logic             load_last,
  output logic             load_ready,
  input  logic             start,
  input  logic [CNT_W-1:0] cycle_budget,
  input  logic [10:0]      dump_words,
  input  logic             halt_det,
  output logic             cpu_enable,
  output logic [31:0]      imem_addr,
  output logic             imem_wen,
  output logic [31:0]      imem_wdata,
  output logic [31:0]      dmem_addr,
  output logic             dmem_ren,
  input  logic [31:0]      dmem_rdata,
  output logic             dump_valid,
  output logic [31:0]      dump_data,
  output logic             dump_last,
  input  logic             dump_ready,
  output logic [CNT_W-1:0] run_cycles,
  output logic             timeout,
  output logic             load_ovf,
  output logic             busy,
  output logic             done,
  output logic [2:0]       dbg_state
);

  localparam logic [31:0]      WADDR_LAST = 32'(IMEM_WORDS - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

  seq_state_t       state, state_next;
  logic             load_ok, beat, start_go, budget_hit, run_finish;
  logic             in_run, in_drain, word_taken;
  logic [CNT_W-1:0] budget_q;
  logic [10:0]      dump_words_q;
  logic [31:0]      waddr;
  logic             waddr_at_last;
  logic             drain_done;
  logic [CNT_W-1:0] drain_cnt_unused;
  logic             run_at_term;
  logic [10:0]      idx;
  logic             idx_last;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and the sender holds its payload
  // stable while valid is high and ready is low.
  assign beat       = load_valid && load_ok;
  assign start_go   = (state == ST_IDLE) && start;
  assign in_run     = (state == ST_RUN);
  assign in_drain   = (state == ST_DRAIN);
  assign word_taken = (state == ST_DUMP_OUT) && dump_ready;
  assign budget_hit = in_run && !halt_det && (budget_q != '0) && run_at_term;

  always_comb begin
    state_next = state;
    load_ok    = 1'b0;
    run_finish = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_RUN;
        end else begin
          load_ok = 1'b1;
          if (load_valid && !load_last) state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        load_ok = 1'b1;
        if (load_valid && load_last) state_next = ST_IDLE;
      end
      ST_RUN: begin
        if (halt_det || budget_hit) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (drain_done) begin
          if (dump_words_q == '0) begin
            state_next = ST_IDLE;
            run_finish = 1'b1;
          end else begin
            state_next = ST_DUMP_RD;
          end
        end
      end
      ST_DUMP_RD:   state_next = ST_DUMP_WAIT;
      ST_DUMP_WAIT: state_next = ST_DUMP_OUT;
      ST_DUMP_OUT: begin
        if (dump_ready) begin
          if (idx_last) begin
            state_next = ST_IDLE;
            run_finish = 1'b1;
          end else begin
            state_next = ST_DUMP_RD;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      imem_wen     <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      load_ovf     <= 1'b0;
      timeout      <= 1'b0;
      budget_q     <= '0;
      dump_words_q <= '0;
      dump_data    <= '0;
      done         <= 1'b0;
    end else begin
      state    <= state_next;
      imem_wen <= beat;
      done     <= run_finish;
      if (beat) begin
        imem_addr  <= word_addr(waddr);
        imem_wdata <= load_data;
      end
      // Clear on a fresh program, but a wrap on that same beat still counts.
      if (beat && waddr_at_last) begin
        load_ovf <= 1'b1;
      end else if (beat && state == ST_IDLE) begin
        load_ovf <= 1'b0;
      end
      if (start_go) begin
        budget_q     <= cycle_budget;
        dump_words_q <= dump_words;
        timeout      <= 1'b0;
      end else if (budget_hit) begin
        timeout <= 1'b1;
      end
      if (state == ST_DUMP_WAIT) dump_data <= dmem_rdata;
    end
  end

  seq_counter #(.W(32)) u_waddr (
    .clk(clk), .rst(rst),
    .clr(beat && (load_last || waddr_at_last)), .en(beat),
    .term(WADDR_LAST), .count(waddr), .at_term(waddr_at_last)
  );

  seq_counter #(.W(CNT_W)) u_run_cnt (
    .clk(clk), .rst(rst),
    .clr(start_go), .en(in_run || in_drain),
    .term(budget_q - CNT_W'(1)), .count(run_cycles), .at_term(run_at_term)
  );

  seq_counter #(.W(CNT_W)) u_drain_cnt (
    .clk(clk), .rst(rst),
    .clr(!in_drain), .en(in_drain),
    .term(DRAIN_LAST), .count(drain_cnt_unused), .at_term(drain_done)
  );

  seq_counter #(.W(11)) u_dump_idx (
    .clk(clk), .rst(rst),
    .clr(start_go), .en(word_taken),
    .term(dump_words_q - 11'd1), .count(idx), .at_term(idx_last)
  );

  // Reset masks the two level-sensitive controls in the same cycle it arrives.
  assign load_ready = load_ok && !rst;
  assign cpu_enable = (in_run || in_drain) && !rst;
  assign dmem_ren   = (state == ST_DUMP_RD);
  assign dmem_addr  = dmem_ren ? word_addr(32'(idx)) : '0;
  assign dump_valid = (state == ST_DUMP_OUT);
  assign dump_last  = dump_valid && idx_last;
  assign busy       = (state != ST_IDLE);
  assign dbg_state  = state;

endmodule

// File: tb/tb_cpu_run_sequencer.sv
// Directed bench for cpu_run_sequencer: a per-cycle vector table for load and
// a basic run, then hand-written sequences for budget, overflow, dump and reset.
module tb_cpu_run_sequencer;
  import cpu_seq_pkg::*;

  localparam int IMEM_WORDS = 512;
  localparam int CNT_W      = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             load_valid, load_last, load_ready, start, halt_det;
  logic [31:0]      load_data;
  logic [CNT_W-1:0] cycle_budget;
  logic [10:0]      dump_words;
  logic             cpu_enable, imem_wen, dmem_ren;
  logic [31:0]      imem_addr, imem_wdata, dmem_addr, dmem_rdata = '0;
  logic             dump_valid, dump_last, dump_ready;
  logic [31:0]      dump_data;
  logic [CNT_W-1:0] run_cycles;
  logic             timeout, load_ovf, busy, done;
  logic [2:0]       dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem [0:15];
  logic [31:0] exp_q[$];
  logic [31:0] addr_q[$];

  always #5 clk = ~clk;

  // Data SRAM model: one-cycle read latency.
  always @(posedge clk) if (dmem_ren) dmem_rdata <= mem[dmem_addr[5:2]];

  cpu_run_sequencer #(.IMEM_WORDS(IMEM_WORDS), .DRAIN_CYCLES(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_ready(load_ready), .start(start), .cycle_budget(cycle_budget),
    .dump_words(dump_words), .halt_det(halt_det), .cpu_enable(cpu_enable),
    .imem_addr(imem_addr), .imem_wen(imem_wen), .imem_wdata(imem_wdata),
    .dmem_addr(dmem_addr), .dmem_ren(dmem_ren), .dmem_rdata(dmem_rdata),
    .dump_valid(dump_valid), .dump_data(dump_data), .dump_last(dump_last),
    .dump_ready(dump_ready), .run_cycles(run_cycles), .timeout(timeout),
    .load_ovf(load_ovf), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  typedef struct {
    logic        lv;
    logic [31:0] ld;
    logic        ll;
    logic        st;
    logic        hd;
    logic        e_lr;
    logic        e_wen;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_en;
    logic        e_done;
    logic [2:0]  e_state;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic lv, input logic [31:0] ld, input logic ll,
                              input logic st, input logic hd, input logic e_lr,
                              input logic e_wen, input logic [31:0] e_addr,
                              input logic [31:0] e_wdata, input logic e_en,
                              input logic e_done, input logic [2:0] e_state);
    vec_t v;
    v.lv = lv; v.ld = ld; v.ll = ll; v.st = st; v.hd = hd;
    v.e_lr = e_lr; v.e_wen = e_wen; v.e_addr = e_addr; v.e_wdata = e_wdata;
    v.e_en = e_en; v.e_done = e_done; v.e_state = e_state;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " state"}, 32'(dbg_state), 32'(ST_IDLE));
    chk({tag, " cpu_enable"}, 32'(cpu_enable), 0);
    chk({tag, " load_ready"}, 32'(load_ready), 0);
    chk({tag, " run_cycles"}, run_cycles, 0);
    chk({tag, " dump_data"}, dump_data, 0);
    chk({tag, " imem_addr|wdata"}, imem_addr | imem_wdata, 0);
    chk({tag, " other flags"},
        32'({imem_wen, dmem_ren, dump_valid, dump_last, timeout, load_ovf, busy, done}), 0);
    chk({tag, " dmem_addr"}, dmem_addr, 0);
  endtask

  // Pulses start, then counts cycles with cpu_enable high; halt_det is raised
  // on RUN cycle halt_at (0 = never). Returns in the first cycle after enable.
  task automatic run_once(input logic [31:0] budget, input logic [10:0] dw,
                          input int halt_at, output int en_cnt);
    @(negedge clk);
    start = 1'b1; cycle_budget = budget; dump_words = dw;
    @(negedge clk);
    start = 1'b0;
    en_cnt = 0;
    for (int k = 1; k <= 300; k++) begin
      halt_det = (k == halt_at);
      #1;
      if (!cpu_enable) break;
      en_cnt++;
      @(negedge clk);
    end
    halt_det = 1'b0;
  endtask

  task automatic load_beats(input int n, output logic [31:0] last_addr,
                            output logic [31:0] last_data, output int nwr,
                            output logic [31:0] addr_2ff);
    nwr = 0; last_addr = '1; last_data = '0; addr_2ff = '1;
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      load_valid = (i < n);
      load_data  = 32'h100 + 32'(i);
      load_last  = (i == n - 1);
      #1;
      if (imem_wen) begin
        nwr++;
        last_addr = imem_addr;
        last_data = imem_wdata;
        if (imem_wdata == 32'h2FF) addr_2ff = imem_addr;
      end
    end
    load_valid = 1'b0; load_last = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "bench timed out");
  end

  initial begin
    int          en_cnt, nwr, word, stall, done_cnt;
    logic [31:0] la, ldat, a2ff, held, e;

    rst = 1'b1; load_valid = 0; load_data = 0; load_last = 0; start = 0;
    cycle_budget = 0; dump_words = 0; halt_det = 0; dump_ready = 0;
    mem[0] = 32'hA; mem[1] = 32'hB; mem[2] = 32'hC;
    for (int i = 3; i < 16; i++) mem[i] = 32'hDEAD_0000 + 32'(i);

    // Program load of three words, then a start that collides with a beat.
    vecs[0] = mk(1, 32'h11, 0, 0, 0, 1, 0, 0, 0, 0, 0, ST_IDLE);
    vecs[1] = mk(1, 32'h22, 0, 0, 0, 1, 1, 0, 32'h11, 0, 0, ST_LOAD);
    vecs[2] = mk(1, 32'h33, 1, 0, 0, 1, 1, 4, 32'h22, 0, 0, ST_LOAD);
    vecs[3] = mk(0, 0, 0, 0, 0, 1, 1, 8, 32'h33, 0, 0, ST_IDLE);
    vecs[4] = mk(1, 32'h99, 0, 1, 0, 0, 0, 0, 0, 0, 0, ST_IDLE);
    for (int i = 5; i <= 13; i++) vecs[i] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, ST_RUN);
    vecs[14] = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, ST_RUN);
    for (int i = 15; i <= 18; i++) vecs[i] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, ST_DRAIN);
    vecs[19] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, ST_IDLE);
    vecs[20] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, ST_IDLE);

    repeat (3) @(negedge clk);
    #1;
    chk_zero("reset held");
    rst = 1'b0;
    #1;
    chk("after reset load_ready", 32'(load_ready), 1);
    chk("after reset busy", 32'(busy), 0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      load_valid = vecs[i].lv; load_data = vecs[i].ld; load_last = vecs[i].ll;
      start = vecs[i].st; halt_det = vecs[i].hd;
      #1;
      chk($sformatf("v%0d load_ready", i), 32'(load_ready), 32'(vecs[i].e_lr));
      chk($sformatf("v%0d imem_wen", i), 32'(imem_wen), 32'(vecs[i].e_wen));
      if (vecs[i].e_wen) begin
        chk($sformatf("v%0d imem_addr", i), imem_addr, vecs[i].e_addr);
        chk($sformatf("v%0d imem_wdata", i), imem_wdata, vecs[i].e_wdata);
      end
      chk($sformatf("v%0d cpu_enable", i), 32'(cpu_enable), 32'(vecs[i].e_en));
      chk($sformatf("v%0d done", i), 32'(done), 32'(vecs[i].e_done));
      chk($sformatf("v%0d state", i), 32'(dbg_state), 32'(vecs[i].e_state));
      chk($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].e_state != ST_IDLE));
    end
    load_valid = 0; start = 0; halt_det = 0;
    chk("halt10 run_cycles", run_cycles, 14);
    chk("halt10 timeout", 32'(timeout), 0);
    chk("load3 load_ovf", 32'(load_ovf), 0);

    // Budget expiry, halt on the budget cycle, early halt under a budget.
    run_once(20, 0, 0, en_cnt);
    chk("budget20 enable cycles", 32'(en_cnt), 24);
    chk("budget20 run_cycles", run_cycles, 24);
    chk("budget20 timeout", 32'(timeout), 1);
    chk("budget20 done", 32'(done), 1);
    run_once(20, 0, 20, en_cnt);
    chk("halt@20 enable cycles", 32'(en_cnt), 24);
    chk("halt@20 timeout", 32'(timeout), 0);
    run_once(5, 0, 3, en_cnt);
    chk("halt@3 budget5 enable cycles", 32'(en_cnt), 7);
    chk("halt@3 budget5 run_cycles", run_cycles, 7);
    chk("halt@3 budget5 timeout", 32'(timeout), 0);
    run_once(1, 0, 0, en_cnt);
    chk("budget1 enable cycles", 32'(en_cnt), 5);
    chk("budget1 timeout", 32'(timeout), 1);

    // Load one word more than the memory holds: wraps to address 0.
    load_beats(IMEM_WORDS + 1, la, ldat, nwr, a2ff);
    chk("ovf write count", 32'(nwr), 32'(IMEM_WORDS + 1));
    chk("ovf top word addr", a2ff, 32'h7FC);
    chk("ovf final addr", la, 0);
    chk("ovf final data", ldat, 32'h300);
    chk("ovf flag", 32'(load_ovf), 1);
    chk("ovf back to idle", 32'(dbg_state), 32'(ST_IDLE));
    load_beats(1, la, ldat, nwr, a2ff);
    chk("reload clears ovf", 32'(load_ovf), 0);
    chk("reload addr", la, 0);
    chk("reload data", ldat, 32'h100);

    // Dump three words, stalling dump_ready for five cycles on the second.
    exp_q = {32'hA, 32'hB, 32'hC};
    addr_q = {32'd0, 32'd4, 32'd8};
    run_once(0, 3, 1, en_cnt);
    chk("dump run enable cycles", 32'(en_cnt), 5);
    word = 0; stall = 0; done_cnt = 0; held = '0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (dmem_ren) begin
        if (addr_q.size() == 0) chk("dump extra read", dmem_addr, 32'hFFFF_FFFF);
        else chk("dump read addr", dmem_addr, addr_q.pop_front());
      end
      if (done) done_cnt++;
      if (dump_valid) begin
        if (word == 1 && stall < 5) begin
          dump_ready = 1'b0;
          if (stall == 0) held = dump_data;
          else chk("dump stall data stable", dump_data, held);
          chk("dump stall last", 32'(dump_last), 0);
          stall++;
        end else begin
          dump_ready = 1'b1;
          e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
          chk($sformatf("dump word%0d data", word), dump_data, e);
          chk($sformatf("dump word%0d last", word), 32'(dump_last), 32'(word == 2));
          word++;
        end
      end else begin
        dump_ready = 1'b0;
      end
      if (!busy) break;
      @(negedge clk);
      #1;
    end
    dump_ready = 1'b0;
    chk("dump words taken", 32'(word), 3);
    chk("dump reads left", 32'(addr_q.size()), 0);
    chk("dump stall cycles", 32'(stall), 5);
    chk("dump done pulses", 32'(done_cnt), 1);
    @(negedge clk); #1;
    chk("dump done falls", 32'(done), 0);

    // Reset while a dump word waits in DUMP_OUT.
    run_once(0, 2, 1, en_cnt);
    for (int k = 0; k < 10 && !dump_valid; k++) begin
      @(negedge clk); #1;
    end
    chk("reach DUMP_OUT", 32'(dbg_state), 32'(ST_DUMP_OUT));
    rst = 1'b1;
    @(negedge clk); #1;
    chk_zero("rst in DUMP_OUT");
    rst = 1'b0;
    #1;
    chk("after dump rst load_ready", 32'(load_ready), 1);

    // Reset in the middle of RUN.
    @(negedge clk);
    start = 1'b1; cycle_budget = 0; dump_words = 0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("mid-run enable", 32'(cpu_enable), 1);
    rst = 1'b1;
    #1;
    chk("rst drops enable at once", 32'(cpu_enable), 0);
    @(negedge clk); #1;
    chk_zero("rst in RUN");
    rst = 1'b0;
    @(negedge clk); #1;
    chk("idle after rst in RUN", 32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cpu_run_sequencer.md
Name: cpu_run_sequencer

Overview:
Sequences one complete program run of the pipelined CPU core in four steps: stream a program into instruction memory, run the core, drain the pipeline, then stream data-memory contents back out.
- Drives the core's enable input.
- Drives the instruction-memory external write port (addr_ext/wen_ext/wdata_ext).
- Drives the data-memory external read port (addr_ext_2/ren_ext_2/rdata_ext_2).
- Sits between the host/testbench and the cpu top level, so no host logic touches the memory ports directly.

Parameters:
IMEM_WORDS, 512, instruction memory depth in words; load address wraps at this depth.
DRAIN_CYCLES, 4, cycles enable stays high after halt so in-flight instructions retire.
CNT_W, 32, width of the cycle counter and cycle_budget.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
load_valid  in  1  program word valid
load_data  in  32  program word
load_last  in  1  final program word
load_ready  out  1  sequencer accepts program word
start  in  1  single-cycle run request
cycle_budget  in  CNT_W  max run cycles, sampled on start; 0 = unlimited
dump_words  in  11  number of data words to dump (0..1024), sampled on start
halt_det  in  1  core has fetched/decoded the halt word
cpu_enable  out  1  enable to the core
imem_addr  out  32  instruction memory external byte address
imem_wen  out  1  instruction memory external write enable
imem_wdata  out  32  instruction memory external write data
dmem_addr  out  32  data memory external byte address
dmem_ren  out  1  data memory external read enable
dmem_rdata  in  32  data memory external read data
dump_valid  out  1  dump word valid
dump_data  out  32  dump word
dump_last  out  1  final dump word
dump_ready  in  1  consumer accepts dump word
run_cycles  out  CNT_W  enabled cycles in last run (RUN+DRAIN)
timeout  out  1  sticky: last run ended on budget
load_ovf  out  1  sticky: load wrapped past IMEM_WORDS
busy  out  1  state is not IDLE
done  out  1  one-cycle pulse when a dump completes

Behaviour:
Clock, reset and outputs:
- One clock: clk. Reset is synchronous and active-high (rst); all state is updated on the rising edge of clk.
- Under rst: state=IDLE and every output is 0, including run_cycles, timeout and load_ovf; the load address and all counters are cleared.
- rst asserted in any state, mid-operation, returns to IDLE on the next edge and drops cpu_enable immediately. Partial memory writes are not undone.

Addressing:
- All memory addresses are byte addresses, word-aligned, stride 4.
- Data SRAM read latency: dmem_rdata is valid exactly one cycle after dmem_ren.

States: IDLE, LOAD, RUN, DRAIN, DUMP_RD, DUMP_WAIT, DUMP_OUT.

IDLE and LOAD (program load):
- load_ready=1 in IDLE and LOAD; 0 in every other state.
- Beat handshake: load_valid & load_ready.
  - A beat registers imem_addr=waddr*4, imem_wdata=load_data and imem_wen=1 for the next cycle only, then increments waddr.
- The first beat in IDLE moves to LOAD and clears load_ovf.
- At waddr==IMEM_WORDS-1, a beat wraps waddr to 0 and sets load_ovf.
- A beat with load_last returns to IDLE and resets waddr to 0.
- start while in LOAD is ignored.

IDLE to RUN:
- start in IDLE samples cycle_budget and dump_words, clears timeout, run_cycles and the dump index, then enters RUN.
- start and load_valid in the same IDLE cycle: start wins and the beat is not accepted (load_ready is 0 in that cycle).

RUN:
- cpu_enable=1; run_cycles increments every cycle.
- halt_det=1 enters DRAIN.
- Otherwise, budget!=0 and run_cycles+1==budget sets timeout and enters DRAIN.
- halt_det and budget expiry in the same cycle: halt wins, timeout=0.

DRAIN:
- cpu_enable=1 for exactly DRAIN_CYCLES cycles; run_cycles keeps counting.
- cpu_enable falls on the edge leaving DRAIN, then the state goes to DUMP_RD.
- If dump_words==0, DRAIN goes to IDLE with the done pulse instead.

Dump:
- DUMP_RD: dmem_ren=1, dmem_addr=idx*4, for one cycle; next state DUMP_WAIT.
- DUMP_WAIT: captures dmem_rdata into dump_data; next state DUMP_OUT.
- DUMP_OUT: dump_valid=1. dump_data is held stable until dump_ready.
  - dump_last=1 when idx==dump_words-1.
  - On dump_ready: idx++. If that was the last word, go to IDLE and pulse done=1 for one cycle; otherwise go to DUMP_RD.
- Throughput: 3 cycles per word minimum.
- dump_ready stalls hold DUMP_OUT indefinitely.

Decomposition:
- Shared package cpu_seq_pkg holds:
  - the state encoding enum (3 bits);
  - the constant WORD_BYTES=4;
  - the halt word HALT_WORD=32'hFFFF_FFFF, used by the core-side halt_det compare.
- One sub-module is natural: seq_counter (CNT_W-wide counter with sync clear, enable and terminal-compare output), instanced for run_cycles, the drain count, waddr and the dump index.

Test Plan:
- Load 3 beats (0x11,0x22,0x33, last on third) with no stalls -> imem writes at addrs 0,4,8 one cycle after each beat; IDLE after the third; load_ovf=0.
- Load IMEM_WORDS+1 beats -> final write at addr 0; load_ovf=1.
- start with budget=0, halt_det asserted on the 10th RUN cycle -> cpu_enable high for 10+4 cycles; run_cycles=14; timeout=0.
- start with budget=20 and no halt -> enable high for 20+4 cycles; timeout=1. Repeat with halt_det on cycle 20 -> timeout=0.
- Dump 3 words (mem 0xA,0xB,0xC) with dump_ready low 5 cycles on word 2 -> reads at addrs 0,4,8; data stable through the stall; dump_last on 0xC only; one done pulse.
- rst during DUMP_OUT, and separately during RUN -> next cycle IDLE with all outputs 0; cpu_enable low.
